// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port between
// the writeback stage (port 0) and the load/debug port (port 1).
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         C,
  input  logic                         nR,
  input  logic                         req0,
  input  logic [ADDR_WIDTH-1:0]        addr0,
  input  logic [DATA_WIDTH-1:0]        data0,
  output logic                         ack0,
  input  logic                         req1,
  input  logic [ADDR_WIDTH-1:0]        addr1,
  input  logic [DATA_WIDTH-1:0]        data1,
  output logic                         ack1,
  output logic [(1<<ADDR_WIDTH)-1:0]   rf_load,
  output logic [DATA_WIDTH-1:0]        rf_data,
  output logic                         busy,
  output logic                         grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    ptr_reg, ptr_next;
  logic                    grant_reg, grant_next;
  logic [ADDR_WIDTH-1:0]   hold_addr_reg, hold_addr_next;
  logic [DATA_WIDTH-1:0]   hold_data_reg, hold_data_next;

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      grant_reg     <= 1'b0;
      hold_addr_reg <= '0;
      hold_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      hold_addr_reg <= hold_addr_next;
      hold_data_reg <= hold_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    hold_addr_next = hold_addr_reg;
    hold_data_next = hold_data_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // A lone requester wins outright; the pointer only breaks ties.
          grant_next     = (req0 && req1) ? ptr_reg : req1;
          hold_addr_next = grant_next ? addr1 : addr0;
          hold_data_next = grant_next ? data1 : data0;
          state_next     = WRITE;
        end
      end
      WRITE: state_next = ACK;
      ACK: begin
        ptr_next   = ~grant_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign ack0    = (state_reg == ACK) && !grant_reg;
  assign ack1    = (state_reg == ACK) && grant_reg;
  assign rf_data = hold_data_reg;
  assign grant   = grant_reg;

  // Load enable 0 is tied off: writes to R0 are dropped but still acknowledged.
  generate
    for (genvar gi = 0; gi < (1 << ADDR_WIDTH); gi++) begin : g_load
      if (gi == 0) begin : g_r0
        assign rf_load[gi] = 1'b0;
      end else begin : g_rn
        assign rf_load[gi] = (state_reg == WRITE) &&
                             (hold_addr_reg == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

endmodule
